// File: rtl/bus_rr_arbiter.sv
// Round-robin bus arbiter with registered one-hot grant and encoded owner index.
// Optional tenure limit with forced revocation when ARB_TIMEOUT_EN is defined.
module bus_rr_arbiter #(
   parameter int N_MASTERS = 4,
   parameter int ID_W      = 2,
   parameter int MAX_HOLD  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_MASTERS-1:0] m_req,
   output logic [N_MASTERS-1:0] m_grnt,
   output logic [ID_W-1:0]      owner_id,
   output logic                 bus_idle,
   output logic                 timeout
);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t                state_q;
   state_t                state_d;
   logic [N_MASTERS-1:0]  grnt_q;
   logic [N_MASTERS-1:0]  grnt_d;
   logic [ID_W-1:0]       owner_q;
   logic [ID_W-1:0]       owner_d;
   logic [ID_W-1:0]       ptr_q;
   logic [ID_W-1:0]       ptr_d;
   logic [N_MASTERS-1:0]  cand;
   logic                  owner_req;
   logic                  win_vld;
   logic [ID_W-1:0]       win_id;
   logic                  revoke;

   if (N_MASTERS < 2 || N_MASTERS > 8 || (2 ** ID_W) < N_MASTERS
       || MAX_HOLD < 2) begin : g_bad_cfg
      $error("bus_rr_arbiter: illegal parameter combination");
   end

   // The owner is never a candidate, so a revoke skips it naturally.
   assign cand      = m_req & ~grnt_q;
   assign owner_req = |(m_req & grnt_q);

   always_comb begin
      win_vld = 1'b0;
      win_id  = '0;
      for (int k = N_MASTERS; k >= 1; k--) begin
         int s;
         s = int'(ptr_q) + k;
         if (s >= N_MASTERS) s = s - N_MASTERS;
         if (cand[s[ID_W-1:0]]) begin
            win_vld = 1'b1;
            win_id  = s[ID_W-1:0];
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(MAX_HOLD);

   logic [CNT_W-1:0] cnt_q;
   logic             tmo_q;

   assign revoke = (state_q == OWNED) && owner_req && win_vld
                   && (cnt_q == CNT_W'(MAX_HOLD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         tmo_q <= 1'b0;
      end else begin
         tmo_q <= revoke;
         if (state_d != OWNED || grnt_d != grnt_q)
            cnt_q <= '0;
         else if (cnt_q != CNT_W'(MAX_HOLD - 1))
            cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign timeout = tmo_q;
`else
   assign revoke  = 1'b0;
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         grnt_q  <= '0;
         owner_q <= '0;
         ptr_q   <= ID_W'(N_MASTERS - 1);
      end else begin
         state_q <= state_d;
         grnt_q  <= grnt_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grnt_d  = grnt_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               state_d = OWNED;
               grnt_d  = N_MASTERS'(1) << win_id;
               owner_d = win_id;
               ptr_d   = win_id;
            end
         end
         OWNED: begin
            if (!owner_req || revoke) begin
               if (win_vld) begin
                  grnt_d  = N_MASTERS'(1) << win_id;
                  owner_d = win_id;
                  ptr_d   = win_id;
               end else begin
                  state_d = IDLE;
                  grnt_d  = '0;
               end
            end
         end
      endcase
   end

   always_comb begin
      m_grnt   = grnt_q;
      owner_id = owner_q;
      bus_idle = (state_q == IDLE);
   end

endmodule
